// File: rtl/recovery_sequencer.sv
// Recovery routine controller for one core: reset, halt, restore PC / register file / CSRs
// from backup storage, then release.
module recovery_sequencer #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumRegs       = 32,
  parameter int unsigned RegfileAddr   = 6,
  parameter int unsigned NumWritePorts = 2,
  parameter int unsigned NumCsrs       = 4,
  parameter int unsigned ResetCycles   = 2,
  parameter int unsigned HaltTimeout   = 64,
  localparam int unsigned CsrIdxW      = (NumCsrs > 1) ? $clog2(NumCsrs) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        start_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        error_o,
  output logic [2:0]                                  state_o,
  output logic                                        core_rst_o,
  output logic                                        halt_req_o,
  input  logic                                        halted_i,
  input  logic [DataWidth-1:0]                        pc_backup_i,
  output logic                                        pc_valid_o,
  output logic [DataWidth-1:0]                        pc_o,
  input  logic                                        pc_ready_i,
  output logic [NumWritePorts-1:0][RegfileAddr-1:0]   bkp_raddr_o,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]     bkp_rdata_i,
  output logic [NumWritePorts-1:0]                    rf_we_o,
  output logic [NumWritePorts-1:0][RegfileAddr-1:0]   rf_waddr_o,
  output logic [NumWritePorts-1:0][DataWidth-1:0]     rf_wdata_o,
  input  logic [NumCsrs-1:0][DataWidth-1:0]           csr_backup_i,
  output logic                                        csr_valid_o,
  output logic [CsrIdxW-1:0]                          csr_idx_o,
  output logic [DataWidth-1:0]                        csr_wdata_o,
  input  logic                                        csr_ready_i
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StReset      = 3'd1;
  localparam logic [2:0] StHaltReq    = 3'd2;
  localparam logic [2:0] StHaltWait   = 3'd3;
  localparam logic [2:0] StRestorePc  = 3'd4;
  localparam logic [2:0] StRestoreRf  = 3'd5;
  localparam logic [2:0] StRestoreCsr = 3'd6;
  localparam logic [2:0] StExit       = 3'd7;

  localparam int unsigned RdCycles = (NumRegs + NumWritePorts - 1) / NumWritePorts;
  localparam int unsigned PtrW     = $clog2(NumRegs + NumWritePorts);
  localparam int unsigned CntMax0  = (ResetCycles > HaltTimeout) ? ResetCycles : HaltTimeout;
  localparam int unsigned CntMax   = (CntMax0 > RdCycles + 1) ? CntMax0 : RdCycles + 1;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  logic [2:0]                                 state_q, state_d;
  logic [CntW-1:0]                            cnt_q, cnt_d;
  logic [PtrW-1:0]                            ptr_q, ptr_d;
  logic [CsrIdxW-1:0]                         idx_q, idx_d;
  logic                                       error_q, error_d;
  logic [NumWritePorts-1:0]                   wvalid_q, wvalid_d;
  logic [NumWritePorts-1:0][RegfileAddr-1:0]  waddr_q, waddr_d;

  logic                                       rd_phase_c;
  logic [NumWritePorts-1:0][PtrW-1:0]         lane_ptr_c;
  logic [NumWritePorts-1:0]                   lane_valid_c;
  logic [NumWritePorts-1:0][RegfileAddr-1:0]  lane_addr_c;

  // Backup read lanes: ptr+p for in-range lanes, address 0 otherwise
  always_comb begin
    rd_phase_c   = (state_q == StRestoreRf) && (cnt_q < CntW'(RdCycles));
    lane_ptr_c   = '0;
    lane_valid_c = '0;
    lane_addr_c  = '0;
    for (int p = 0; p < int'(NumWritePorts); p++) begin
      lane_ptr_c[p]   = ptr_q + PtrW'(p);
      lane_valid_c[p] = rd_phase_c && (lane_ptr_c[p] < PtrW'(NumRegs));
      lane_addr_c[p]  = lane_valid_c[p] ? RegfileAddr'(lane_ptr_c[p]) : '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    error_d  = error_q;
    wvalid_d = lane_valid_c;
    waddr_d  = lane_addr_c;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StReset;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      StReset: begin
        if (cnt_q == CntW'(ResetCycles - 1)) begin
          state_d = StHaltReq;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHaltReq: begin
        state_d = StHaltWait;
        cnt_d   = '0;
      end
      StHaltWait: begin
        // A halt acknowledge on the final timeout cycle still counts as success
        if (halted_i) begin
          state_d = StRestorePc;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(HaltTimeout - 1)) begin
          state_d = StExit;
          error_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRestorePc: begin
        if (pc_ready_i) begin
          state_d = StRestoreRf;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      StRestoreRf: begin
        // RdCycles read cycles plus one drain cycle for the last write
        if (rd_phase_c) ptr_d = ptr_q + PtrW'(NumWritePorts);
        if (cnt_q == CntW'(RdCycles)) begin
          state_d = StRestoreCsr;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRestoreCsr: begin
        if (csr_ready_i) begin
          if (idx_q == CsrIdxW'(NumCsrs - 1)) begin
            state_d = StExit;
          end else begin
            idx_d = idx_q + CsrIdxW'(1);
          end
        end
      end
      StExit:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      error_q  <= 1'b0;
      wvalid_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      error_q  <= error_d;
      wvalid_q <= wvalid_d;
      waddr_q  <= waddr_d;
    end
  end

  assign state_o     = state_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StExit);
  assign error_o     = error_q;
  assign core_rst_o  = (state_q == StReset);
  assign halt_req_o  = (state_q >= StHaltReq) && (state_q <= StRestoreCsr);
  assign pc_valid_o  = (state_q == StRestorePc);
  assign pc_o        = pc_valid_o ? pc_backup_i : '0;
  assign bkp_raddr_o = lane_addr_c;
  assign rf_we_o     = wvalid_q;
  assign rf_waddr_o  = waddr_q;
  assign csr_valid_o = (state_q == StRestoreCsr);
  assign csr_idx_o   = csr_valid_o ? idx_q : '0;
  assign csr_wdata_o = csr_valid_o ? csr_backup_i[idx_q] : '0;

  // Backup data arrives one cycle after its address; pair it with the registered lane
  always_comb begin
    rf_wdata_o = '0;
    for (int p = 0; p < int'(NumWritePorts); p++) begin
      rf_wdata_o[p] = wvalid_q[p] ? bkp_rdata_i[p] : '0;
    end
  end

endmodule
